// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin, burst-bounded arbiter sharing one single-port memory between two requesters
// Ports: clk_i/rst_i clock and sync active-high reset; reqK_i/weK_i/addrK_i/wdataK_i requester K transfer;
// ackK_o transfer accepted this cycle; rvalidK_o read data for K on rdata_o; mem_* memory drive and
// mem_rdata_i return (1-cycle latency); owner_o current owner (00 none, 01 req0, 10 req1).
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_i,
  input  logic                  we0_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  output logic                  ack0_o,
  output logic                  rvalid0_o,
  input  logic                  req1_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  ack1_o,
  output logic                  rvalid1_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [1:0]            owner_o
);
  localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST - 1);
  typedef enum logic [1:0] {O_NONE = 2'b00, O_P0 = 2'b01, O_P1 = 2'b10} own_e;
  own_e          own_q, own_d, oth;
  logic          last_q, last_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          rv0_q, rv1_q;
  logic          is1, mine, other;
  assign ack0_o      = (own_q == O_P0) & req0_i;
  assign ack1_o      = (own_q == O_P1) & req1_i;
  assign mem_en_o    = ack0_o | ack1_o;
  assign mem_we_o    = ack0_o ? we0_i : ack1_o & we1_i;
  assign mem_addr_o  = ack0_o ? addr0_i : ack1_o ? addr1_i : '0;
  assign mem_wdata_o = ack0_o ? wdata0_i : ack1_o ? wdata1_i : '0;
  assign rdata_o     = mem_rdata_i;
  assign rvalid0_o   = rv0_q;
  assign rvalid1_o   = rv1_q;
  assign owner_o     = own_q;
  // View of the current owner as "mine" vs the "other" requester, so both owner states share one rule set.
  assign is1   = own_q == O_P1;
  assign mine  = is1 ? req1_i : req0_i;
  assign other = is1 ? req0_i : req1_i;
  assign oth   = is1 ? O_P0 : O_P1;
  always_comb begin
    own_d   = own_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (own_q)
      O_NONE: begin
        own_d   = (req0_i & req1_i) ? (last_q ? O_P0 : O_P1) : req0_i ? O_P0 : req1_i ? O_P1 : O_NONE;
        burst_d = '0;
      end
      O_P0, O_P1: begin
        if (mine & other & (burst_q == BMAX)) begin
          own_d   = oth;
          last_d  = is1;
          burst_d = '0;
        end else if (mine) begin
          burst_d = (burst_q == BMAX) ? BMAX : burst_q + 1'b1;
        end else begin
          own_d   = other ? oth : O_NONE;
          last_d  = is1;
          burst_d = '0;
        end
      end
      default: own_d = O_NONE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      own_q   <= O_NONE;
      last_q  <= 1'b1;
      burst_q <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      own_q   <= own_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      rv0_q   <= ack0_o & ~we0_i;
      rv1_q   <= ack1_o & ~we1_i;
    end
  end
endmodule
